// File: rtl/vga_text_writer.sv
// vga_text_writer
// Wishbone master feeding the VGA text controller's register port. Holds a
// cursor on the character grid, interprets CR/LF/BS, issues the register
// write sequence per glyph or screen clear and polls the controller's busy
// bit before taking the next byte.
module vga_text_writer #(
    parameter int COLS       = 40,
    parameter int ROWS       = 30,
    parameter int POLL_LIMIT = 400000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [7:0]  ch_data,
    input  logic        ch_valid,
    output logic        ch_ready,
    input  logic        clear_req,
    input  logic [23:0] fg_color,
    input  logic [23:0] bg_color,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [7:0]  wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    output logic [4:0]  cursor_row,
    output logic [5:0]  cursor_col,
    output logic        busy,
    output logic        err
);

    localparam int PW = $clog2(POLL_LIMIT + 1);

    localparam logic [7:0] ADR_CTRL   = 8'h00;
    localparam logic [7:0] ADR_STATUS = 8'h04;
    localparam logic [7:0] ADR_POS    = 8'h08;
    localparam logic [7:0] ADR_ASCII  = 8'h0C;
    localparam logic [7:0] ADR_FG     = 8'h10;
    localparam logic [7:0] ADR_BG     = 8'h14;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        DECODE   = 4'd1,
        WR_POS   = 4'd2,
        WR_ASCII = 4'd3,
        WR_FG    = 4'd4,
        WR_BG    = 4'd5,
        WR_CTRL  = 4'd6,
        POLL     = 4'd7,
        GAP      = 4'd8
    } state_t;

    state_t        state_q, state_d;
    state_t        ret_q, ret_d;        // state entered when the gap ends
    logic          gap_q, gap_d;        // one extra idle cycle (after control write)
    logic [7:0]    byte_q, byte_d;
    logic [23:0]   fg_q, fg_d;
    logic [23:0]   bg_q, bg_d;
    logic          clr_mode_q, clr_mode_d;
    logic          clr_pend_q, clr_pend_d;
    logic [4:0]    row_q, row_d;
    logic [5:0]    col_q, col_d;
    logic [PW-1:0] poll_q, poll_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;
    logic          cyc_q, cyc_d;
    logic          we_q, we_d;
    logic [7:0]    adr_q, adr_d;
    logic [31:0]   dat_q, dat_d;
    logic [3:0]    sel_q, sel_d;

    logic          ch_ready_s;
    logic          accept_s;
    logic          unused_s;

    // Row advance wraps to the top line; the screen never scrolls.
    function automatic logic [4:0] row_inc(input logic [4:0] r);
        if (r == 5'(ROWS - 1)) begin
            return 5'd0;
        end else begin
            return r + 5'd1;
        end
    endfunction

    assign ch_ready_s = (state_q == IDLE) && !clr_pend_q && !clear_req && !wb_rst_i;
    assign accept_s   = ch_valid && ch_ready_s;
    assign unused_s   = ^wbm_dat_i[31:1];

    // Next-state, cursor and bus-request computation; bus outputs follow the next state.
    always_comb begin
        state_d    = state_q;
        ret_d      = ret_q;
        gap_d      = gap_q;
        byte_d     = byte_q;
        fg_d       = fg_q;
        bg_d       = bg_q;
        clr_mode_d = clr_mode_q;
        clr_pend_d = clr_pend_q | clear_req;
        row_d      = row_q;
        col_d      = col_q;
        poll_d     = poll_q;
        err_d      = err_q;

        case (state_q)
            IDLE: begin
                if (clr_pend_q || clear_req) begin
                    state_d    = WR_BG;
                    clr_mode_d = 1'b1;
                    bg_d       = bg_color;
                    clr_pend_d = 1'b0;
                end else if (accept_s) begin
                    state_d    = DECODE;
                    clr_mode_d = 1'b0;
                    byte_d     = ch_data;
                    fg_d       = fg_color;
                    bg_d       = bg_color;
                end else begin
                    state_d = IDLE;
                end
            end
            DECODE: begin
                if (byte_q >= 8'h20 && byte_q <= 8'h7E) begin
                    state_d = WR_POS;
                end else begin
                    state_d = IDLE;
                    case (byte_q)
                        8'h0A: begin
                            col_d = 6'd0;
                            row_d = row_inc(row_q);
                        end
                        8'h0D: begin
                            col_d = 6'd0;
                        end
                        8'h08: begin
                            if (col_q != 6'd0) begin
                                col_d = col_q - 6'd1;
                            end else begin
                                col_d = col_q;
                            end
                        end
                        default: begin
                            col_d = col_q;
                        end
                    endcase
                end
            end
            WR_POS, WR_ASCII, WR_FG, WR_BG, WR_CTRL: begin
                if (wbm_err_i) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (wbm_ack_i) begin
                    state_d = GAP;
                    gap_d   = (state_q == WR_CTRL);
                    poll_d  = {PW{1'b0}};
                    case (state_q)
                        WR_POS:   ret_d = WR_ASCII;
                        WR_ASCII: ret_d = WR_FG;
                        WR_FG:    ret_d = WR_BG;
                        WR_BG:    ret_d = WR_CTRL;
                        WR_CTRL:  ret_d = POLL;
                        default:  ret_d = IDLE;
                    endcase
                end else begin
                    state_d = state_q;
                end
            end
            POLL: begin
                if (wbm_err_i) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (wbm_ack_i) begin
                    if (wbm_dat_i[0]) begin
                        if (poll_q == PW'(POLL_LIMIT - 1)) begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end else begin
                            poll_d  = poll_q + PW'(1);
                            state_d = GAP;
                            ret_d   = POLL;
                            gap_d   = 1'b0;
                        end
                    end else begin
                        state_d = IDLE;
                        if (clr_mode_q) begin
                            row_d = 5'd0;
                            col_d = 6'd0;
                        end else if (col_q == 6'(COLS - 1)) begin
                            col_d = 6'd0;
                            row_d = row_inc(row_q);
                        end else begin
                            col_d = col_q + 6'd1;
                            row_d = row_q;
                        end
                    end
                end else begin
                    state_d = state_q;
                end
            end
            GAP: begin
                if (gap_q) begin
                    gap_d = 1'b0;
                end else begin
                    state_d = ret_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cyc_d = 1'b0;
        we_d  = 1'b0;
        adr_d = 8'h00;
        dat_d = 32'h0000_0000;
        case (state_d)
            WR_POS: begin
                cyc_d = 1'b1;
                we_d  = 1'b1;
                adr_d = ADR_POS;
                dat_d = {19'h0, row_q, 2'b00, col_q};
            end
            WR_ASCII: begin
                cyc_d = 1'b1;
                we_d  = 1'b1;
                adr_d = ADR_ASCII;
                dat_d = {24'h0, byte_d};
            end
            WR_FG: begin
                cyc_d = 1'b1;
                we_d  = 1'b1;
                adr_d = ADR_FG;
                dat_d = {8'h0, fg_d};
            end
            WR_BG: begin
                cyc_d = 1'b1;
                we_d  = 1'b1;
                adr_d = ADR_BG;
                dat_d = {8'h0, bg_d};
            end
            WR_CTRL: begin
                cyc_d = 1'b1;
                we_d  = 1'b1;
                adr_d = ADR_CTRL;
                dat_d = clr_mode_d ? 32'h0000_0002 : 32'h0000_0001;
            end
            POLL: begin
                cyc_d = 1'b1;
                we_d  = 1'b0;
                adr_d = ADR_STATUS;
                dat_d = 32'h0000_0000;
            end
            default: begin
                cyc_d = 1'b0;
            end
        endcase
        sel_d  = cyc_d ? 4'hF : 4'h0;
        busy_d = (state_d != IDLE) || clr_pend_d;
    end

    // State, cursor, latched byte/colours and registered bus outputs.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= IDLE;
            ret_q      <= IDLE;
            gap_q      <= 1'b0;
            byte_q     <= 8'h00;
            fg_q       <= 24'h0;
            bg_q       <= 24'h0;
            clr_mode_q <= 1'b0;
            clr_pend_q <= 1'b0;
            row_q      <= 5'd0;
            col_q      <= 6'd0;
            poll_q     <= {PW{1'b0}};
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            cyc_q      <= 1'b0;
            we_q       <= 1'b0;
            adr_q      <= 8'h00;
            dat_q      <= 32'h0000_0000;
            sel_q      <= 4'h0;
        end else begin
            state_q    <= state_d;
            ret_q      <= ret_d;
            gap_q      <= gap_d;
            byte_q     <= byte_d;
            fg_q       <= fg_d;
            bg_q       <= bg_d;
            clr_mode_q <= clr_mode_d;
            clr_pend_q <= clr_pend_d;
            row_q      <= row_d;
            col_q      <= col_d;
            poll_q     <= poll_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            cyc_q      <= cyc_d;
            we_q       <= we_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            sel_q      <= sel_d;
        end
    end

    assign ch_ready   = ch_ready_s;
    assign wbm_cyc_o  = cyc_q;
    assign wbm_stb_o  = cyc_q;
    assign wbm_we_o   = we_q;
    assign wbm_adr_o  = adr_q;
    assign wbm_dat_o  = dat_q;
    assign wbm_sel_o  = sel_q;
    assign cursor_row = row_q;
    assign cursor_col = col_q;
    assign busy       = busy_q;
    assign err        = err_q;

endmodule

// File: doc/vga_text_writer.md
# vga_text_writer

Wishbone master that drives the VGA character display controller's register port, turning a byte stream into rendered characters on the 40x30 text grid. It keeps a cursor, interprets basic control characters, issues the register write sequence per glyph or screen clear, and polls the controller's busy bit before releasing the next byte. It sits between a byte source (UART RX, CPU FIFO) and the VGA controller's Wishbone slave port.

## Interface
- COLS, 40, grid columns.
- ROWS, 30, grid rows.
- POLL_LIMIT, 400000, max status reads per poll phase before timeout.
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- ch_data  in  8  input byte.
- ch_valid  in  1  byte valid.
- ch_ready  out  1  byte accepted when ch_valid && ch_ready.
- clear_req  in  1  one-cycle pulse: fill screen with bg_color and home cursor.
- fg_color  in  24  glyph colour {R,G,B}, sampled at byte accept.
- bg_color  in  24  background colour, sampled at byte accept / clear start.
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone master strobes.
- wbm_adr_o  out  8  byte address.
- wbm_dat_o  out  32  write data.
- wbm_sel_o  out  4  always 4'hF during a cycle.
- wbm_dat_i  in  32  read data.
- wbm_ack_i, wbm_err_i  in  1 each  termination.
- cursor_row  out  5  current row; cursor_col  out  6  current column.
- busy  out  1  state != IDLE or clear pending.
- err  out  1  sticky: bus error or poll timeout.

## Operation
- Target map: 0x00 control (bit0 char, bit1 bg fill), 0x04 status (bit0 busy), 0x08 position {row[12:8], col[5:0]}, 0x0C ascii, 0x10 char colour, 0x14 bg colour.
- States: IDLE, DECODE, WR_POS, WR_ASCII, WR_FG, WR_BG, WR_CTRL, POLL, GAP.
- IDLE: clear pending (or clear_req this cycle) has priority -> WR_BG; else accept byte -> DECODE. ch_ready = IDLE && !clear pending && !clear_req && !wb_rst_i.
- clear_req while not IDLE: latched as pending, serviced at next IDLE; multiple pulses collapse to one.
- DECODE: 0x20-0x7E -> WR_POS; 0x0A -> col 0, row+1; 0x0D -> col 0; 0x08 -> col-1 if col>0 else unchanged; all other bytes consumed silently. Non-printables return to IDLE, no bus traffic.
- Glyph sequence: 0x08 <- row<<8|col, 0x0C <- byte, 0x10 <- fg, 0x14 <- bg, 0x00 <- 1, then POLL.
- Clear sequence: 0x14 <- bg, 0x00 <- 2, then POLL; on completion cursor = (0,0).
- POLL: read 0x04; bit0=1 -> repeat read; bit0=0 -> done. Glyph done: col+1; col==COLS-1 -> col 0, row+1. Row increment past ROWS-1 wraps to 0 (no scroll).
- Colour data zero-extended to 32 bits.
- wbm_err_i on any transaction: err set, sequence aborted, cursor unchanged, -> IDLE.
- POLL_LIMIT reads with bit0 still 1: err set, -> IDLE, cursor unchanged.

## Timing
- Reset values: all wbm_* outputs 0, cursor (0,0), busy 0, err 0, ch_ready 0 during reset, state IDLE, clear pending 0.
- One transaction outstanding; cyc/stb/we/adr/dat registered, held stable until ack or err; wait states tolerated.
- After each termination, cyc/stb low for exactly one GAP cycle before next transaction.
- After the control write, two idle cycles before the first status read so target busy is visible.
- Read data sampled on the ack cycle.
- With zero-wait-state target: byte accept -> DECODE 1 cycle; glyph writes 5x2 cycles; first poll 2 cycles after control ack.
- Reset mid-transaction: cyc/stb drop immediately (async), sequence lost, cursor (0,0).
- Byte accepted and clear_req same cycle impossible (ready low when clear_req high).

## Test plan
- Byte 0x41 at (0,0), fg 0xFF0000, bg 0x000000, zero-wait target busy 3 polls -> writes 0x08=0x0, 0x0C=0x41, 0x10=0xFF0000, 0x14=0x0, 0x00=0x1; reads until bit0=0; cursor (0,1).
- Cursor (29,39), byte 0x5A -> position write 0x1D27; cursor wraps to (0,0).
- Bytes 0x0D, 0x0A, 0x08 at (3,0) and 0x07 -> no bus cycles, cursor (4,0), ch_ready reasserted each time.
- clear_req pulse during glyph poll -> after glyph, writes 0x14=bg, 0x00=0x2, polls; cursor (0,0); second pulse during that clear causes one extra clear only.
- wbm_err_i on ASCII write -> err=1, no further writes, cursor unchanged; target stuck busy -> err after POLL_LIMIT reads.
- wb_rst_i asserted with stb high and ack withheld -> cyc/stb 0 same cycle, cursor (0,0), err 0 after release.
